dmg_fb_arbiter: RTL

DMG_FB_ARBITER -- requirements
Module: dmg_fb_arbiter

---
 rtl/dmg_fb_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dmg_fb_arbiter.sv
// rtl/dmg_fb_arbiter.sv - framebuffer RAM arbiter between the LCD pixel fetch and a host port
// LCD byte fetches always win over host accesses; one byte is prefetched per 4-pixel group.
module dmg_fb_arbiter #(
  parameter int FB_BYTES   = 5760,
  parameter int LINE_BYTES = 40
) (
  input  logic        clk_8m,
  input  logic        rst_n,
  input  logic [8:0]  lcd_xpos,
  input  logic [7:0]  lcd_ypos,
  output logic [1:0]  pix_out,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [12:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        underrun
);

  typedef enum logic [2:0] {IDLE, LCD_RD, LCD_WAIT, HOST_ACC, HOST_WAIT} state_t;

  localparam logic [13:0] FB_LIMIT = 14'(FB_BYTES);
  localparam logic [12:0] LINE_B13 = 13'(LINE_BYTES);

  state_t      r_state;
  state_t      w_state_next;
  logic [8:0]  r_xpos_prev;
  logic [7:0]  r_ypos;
  logic        r_prev_ok;
  logic        r_pending;
  logic [12:0] r_fetch_addr;
  logic [7:0]  r_next_byte;
  logic [7:0]  r_cur_byte;
  logic        r_next_valid;
  logic        r_host_ack;
  logic        r_host_rd;
  logic [12:0] r_ram_addr;
  logic        r_ram_we;
  logic [7:0]  r_ram_wdata;
  logic        r_underrun;

  logic        w_step;
  logic        w_fetch_qual;
  logic        w_disp_step;
  logic        w_oob_ack;
  logic        w_host_in_range;
  logic [8:0]  w_xp4;
  logic [12:0] w_fetch_addr;
  logic [2:0]  w_pix_sel;

  // r_prev_ok keeps the first post-reset cycle from looking like an xpos step
  assign w_step          = r_prev_ok && (lcd_xpos != r_xpos_prev);
  assign w_xp4           = lcd_xpos + 9'd4;
  assign w_fetch_qual    = w_step && (lcd_xpos[1:0] == 2'b00) && (w_xp4 < 9'd160) && (lcd_ypos < 8'd144);
  assign w_disp_step     = w_step && (lcd_xpos[1:0] == 2'b00) && (lcd_xpos < 9'd160) && (lcd_ypos < 8'd144);
  assign w_fetch_addr    = {5'd0, lcd_ypos} * LINE_B13 + {6'd0, w_xp4[8:2]};
  assign w_host_in_range = {1'b0, host_addr} < FB_LIMIT;

  always_comb begin
    w_state_next = r_state;
    w_oob_ack    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pending) begin
          w_state_next = LCD_RD;
        end else if (host_req && !r_host_ack) begin
          if (w_host_in_range) w_state_next = HOST_ACC;
          else                 w_oob_ack    = 1'b1;
        end
      end
      LCD_RD:    w_state_next = LCD_WAIT;
      LCD_WAIT:  w_state_next = IDLE;
      HOST_ACC:  w_state_next = HOST_WAIT;
      HOST_WAIT: w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      r_xpos_prev  <= 9'd0;
      r_ypos       <= 8'd0;
      r_prev_ok    <= 1'b0;
      r_pending    <= 1'b0;
      r_fetch_addr <= 13'd0;
    end else begin
      r_xpos_prev <= lcd_xpos;
      r_ypos      <= lcd_ypos;
      r_prev_ok   <= 1'b1;
      if (w_fetch_qual) begin
        r_pending    <= 1'b1;
        r_fetch_addr <= w_fetch_addr;
      end else if (r_state == LCD_RD) begin
        r_pending <= 1'b0;
      end
    end
  end

  // A byte captured in LCD_WAIT on the very step cycle goes straight to the display register
  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      r_next_byte  <= 8'h00;
      r_cur_byte   <= 8'h00;
      r_next_valid <= 1'b0;
      r_underrun   <= 1'b0;
    end else if (w_disp_step) begin
      r_next_valid <= 1'b0;
      if (r_state == LCD_WAIT) begin
        r_next_byte <= ram_rdata;
        r_cur_byte  <= ram_rdata;
      end else if (r_next_valid) begin
        r_cur_byte <= r_next_byte;
      end else begin
        r_cur_byte <= 8'h00;
        r_underrun <= 1'b1;
      end
    end else if (r_state == LCD_WAIT) begin
      r_next_byte  <= ram_rdata;
      r_next_valid <= 1'b1;
    end
  end

  // RAM controls are registered on state entry so they are stable for the whole access cycle
  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_addr  <= 13'd0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= 8'h00;
      r_host_ack  <= 1'b0;
      r_host_rd   <= 1'b0;
    end else begin
      r_ram_we   <= 1'b0;
      r_host_ack <= (w_state_next == HOST_WAIT) || w_oob_ack;
      if (w_state_next == LCD_RD) begin
        r_ram_addr <= r_fetch_addr;
      end else if (w_state_next == HOST_ACC) begin
        r_ram_addr <= host_addr;
        r_ram_we   <= host_we;
        r_host_rd  <= !host_we;
        if (host_we) r_ram_wdata <= host_wdata;
      end
    end
  end

  assign w_pix_sel  = {r_xpos_prev[1:0], 1'b0};
  assign pix_out    = ((r_xpos_prev < 9'd160) && (r_ypos < 8'd144)) ? r_cur_byte[w_pix_sel +: 2] : 2'b00;
  assign host_ack   = r_host_ack;
  assign host_rdata = ((r_state == HOST_WAIT) && r_host_rd) ? ram_rdata : 8'h00;
  assign ram_addr   = r_ram_addr;
  assign ram_we     = r_ram_we;
  assign ram_wdata  = r_ram_wdata;
  assign underrun   = r_underrun;

endmodule
